birukee_input_loader: RTL and testbench
=======================================

BIRUKEE_INPUT_LOADER -- requirements
Module: birukee_input_loader

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 16, the bit width of one systolic operand slice.
REQ-002 SHALL have parameter MAX_SLICE_NUM, default 4, the number of slices per bundle; IN_WIDTH*MAX_SLICE_NUM SHALL equal 64.
REQ-003 SHALL use one clock; reset is synchronous and active-high, with ports named clk and rst.
REQ-004 SHALL have the following ports (name, direction, width, meaning):
 - clk  in  1  clock
 - rst  in  1  sync active-high reset
 - start  in  1  one-cycle load request
 - base_index  in  32  DMA word index of the first beat
 - num_pairs  in  32  north/west bundle pairs to load; legal range 0..2^31-1
 - dma_read_ctrl_valid  out  1  read request valid
 - dma_read_ctrl_ready  in  1  read request accepted
 - dma_read_ctrl_data_index  out  32  request index
 - dma_read_ctrl_data_length  out  32  request length in beats
 - dma_read_ctrl_data_size  out  3  beat size code
 - dma_read_chnl_valid  in  1  read beat valid
 - dma_read_chnl_ready  out  1  read beat accepted
 - dma_read_chnl_data  in  64  read beat
 - out_valid  out  1  bundle pair valid
 - out_ready  in  1  downstream tile accepts the pair
 - out_north_bundle  out  IN_WIDTH*MAX_SLICE_NUM  north operands
 - out_west_bundle  out  IN_WIDTH*MAX_SLICE_NUM  west operands
 - busy  out  1  high whenever state is not IDLE
 - load_done  out  1  one-cycle completion pulse

Function
REQ-005 SHALL implement the states IDLE, REQ, DATA, DRAIN and DONE.
REQ-006 IDLE: when start=1 and num_pairs>0, SHALL capture base_index and num_pairs and move to REQ; when start=1 and num_pairs=0, SHALL move to DONE without issuing a request.
REQ-007 start SHALL be ignored in every state except IDLE.
REQ-008 REQ: SHALL drive dma_read_ctrl_valid=1, index=captured base_index, length=2*num_pairs, size=3'b011; the valid and the request fields SHALL stay stable until dma_read_ctrl_ready=1, after which the state SHALL move to DATA.
REQ-009 DATA: beats SHALL be received in order; beat 2k is the north bundle of pair k and beat 2k+1 is its west bundle.
REQ-010 Slice j of a bundle SHALL be beat bits [IN_WIDTH*(j+1)-1 : IN_WIDTH*j].
REQ-011 Even beats SHALL load the north hold register; dma_read_chnl_ready SHALL be high for an even beat only when the hold register is empty.
REQ-012 Odd beats SHALL be accepted only when out_valid=0 or out_ready=1, which allows a same-cycle drain and refill.
REQ-013 On an accepted odd beat at cycle t, out_north_bundle (from the hold register) and out_west_bundle (from the beat) SHALL be valid with out_valid=1 at t+1, and the hold register SHALL be emptied.
REQ-014 out_valid and the bundle outputs SHALL hold until out_valid and out_ready are both 1.
REQ-015 dma_read_chnl_ready SHALL be 0 outside DATA.
REQ-016 A 32-bit beat counter SHALL count accepted beats; when beat 2*num_pairs-1 is accepted, the state SHALL move to DRAIN.
REQ-017 DRAIN: SHALL move to DONE in the cycle after the final pair is handshaken.
REQ-018 DONE: SHALL assert load_done=1 for exactly one cycle, then return to IDLE.

Reset
REQ-019 While rst=1, at any state including mid-transfer, the block SHALL return to IDLE and SHALL drive all valid outputs 0, load_done 0, busy 0, the bundle outputs 0, the DMA fields 0, and the counters and hold register 0/empty.

Structure
REQ-020 IN_WIDTH, MAX_SLICE_NUM, the DMA size constant 3'b011 and the state enumeration SHALL reside in the shared package birukee_pkg.
REQ-021 SHALL be a single module with no sub-module.

Verification
REQ-022 start, base_index=0x100, num_pairs=3, with ctrl_ready delayed 4 cycles -> request index 0x100 and length 6 held stable; three pairs are output; load_done pulses once; busy drops in the same cycle as the return to IDLE.
REQ-023 Beats 0x1111..., 0x2222... with out_ready=1 -> out_north=0x1111..., out_west=0x2222..., and out_valid is high in the cycle after the second beat is accepted.
REQ-024 out_ready held at 0 for 10 cycles with 2 pairs pending -> at most one north beat is absorbed, dma_read_chnl_ready stays 0 for the next odd beat, and the outputs stay stable.
REQ-025 num_pairs=0 with start -> no dma_read_ctrl_valid is issued and load_done pulses 2 cycles after start.
REQ-026 rst asserted after 3 of 8 beats -> all outputs are at reset values on the next cycle; a following start with num_pairs=1 completes normally.
REQ-027 start pulsed during DATA -> it is ignored and no second request is issued.

Source files
------------

// File: rtl/birukee_pkg.sv
// Shared definitions for the birukee systolic input loader.
package birukee_pkg;

    localparam int IN_WIDTH      = 16;
    localparam int MAX_SLICE_NUM = 4;
    localparam int BUNDLE_W      = IN_WIDTH * MAX_SLICE_NUM;

    // 64-bit beats on the DMA read channel
    localparam logic [2:0] DMA_SIZE = 3'b011;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_DATA,
        ST_DRAIN,
        ST_DONE
    } load_state_t;

    typedef struct packed {
        logic [31:0] index;
        logic [31:0] length;
        logic [2:0]  size;
    } dma_req_t;

    typedef struct packed {
        logic [BUNDLE_W-1:0] north;
        logic [BUNDLE_W-1:0] west;
    } pair_t;

endpackage

// File: rtl/birukee_input_loader.sv
// Fetches num_pairs north/west bundle pairs over one DMA read and presents them to the tile.
// Latency: request one cycle after start; a pair is valid the cycle after its west beat is taken.
// Backpressure: one north beat is buffered; west beats stall while an unaccepted pair is held.
module birukee_input_loader #(
    parameter int IN_WIDTH      = birukee_pkg::IN_WIDTH,
    parameter int MAX_SLICE_NUM = birukee_pkg::MAX_SLICE_NUM
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [31:0]                       base_index,
    input  logic [31:0]                       num_pairs,
    output logic                              dma_read_ctrl_valid,
    input  logic                              dma_read_ctrl_ready,
    output logic [31:0]                       dma_read_ctrl_data_index,
    output logic [31:0]                       dma_read_ctrl_data_length,
    output logic [2:0]                        dma_read_ctrl_data_size,
    input  logic                              dma_read_chnl_valid,
    output logic                              dma_read_chnl_ready,
    input  logic [63:0]                       dma_read_chnl_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [IN_WIDTH*MAX_SLICE_NUM-1:0] out_north_bundle,
    output logic [IN_WIDTH*MAX_SLICE_NUM-1:0] out_west_bundle,
    output logic                              busy,
    output logic                              load_done
);
    import birukee_pkg::*;

    load_state_t   state;
    dma_req_t      req_q;
    logic          req_vld_q;
    pair_t         pair_q;
    logic          out_vld_q;
    logic [BUNDLE_W-1:0] hold_q;
    logic          hold_full;
    logic [31:0]   total_beats;
    logic [31:0]   beat_cnt;
    logic          done_q;

    logic          beat_odd;
    logic          last_beat;
    logic          pair_fire;
    logic          chnl_rdy;
    logic          beat_acc;

    assign beat_odd  = beat_cnt[0];
    assign last_beat = (beat_cnt == total_beats - 32'd1);
    assign pair_fire = out_vld_q && out_ready;

    // West beats may refill the output register in the same cycle it drains.
    assign chnl_rdy = !rst && (state == ST_DATA) &&
                      (beat_odd ? (!out_vld_q || out_ready) : !hold_full);
    assign beat_acc = dma_read_chnl_valid && chnl_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            req_q       <= '0;
            req_vld_q   <= 1'b0;
            pair_q      <= '0;
            out_vld_q   <= 1'b0;
            hold_q      <= '0;
            hold_full   <= 1'b0;
            total_beats <= '0;
            beat_cnt    <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;

            if (pair_fire) begin
                out_vld_q <= 1'b0;
            end

            if (beat_acc) begin
                beat_cnt <= beat_cnt + 32'd1;
                if (!beat_odd) begin
                    hold_q    <= dma_read_chnl_data;
                    hold_full <= 1'b1;
                end else begin
                    pair_q.north <= hold_q;
                    pair_q.west  <= dma_read_chnl_data;
                    out_vld_q    <= 1'b1;
                    hold_full    <= 1'b0;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        beat_cnt  <= '0;
                        hold_full <= 1'b0;
                        if (num_pairs == 32'd0) begin
                            state <= ST_DONE;
                        end else begin
                            req_q       <= '{index: base_index, length: num_pairs << 1, size: DMA_SIZE};
                            req_vld_q   <= 1'b1;
                            total_beats <= num_pairs << 1;
                            state       <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (dma_read_ctrl_ready) begin
                        req_vld_q <= 1'b0;
                        state     <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (beat_acc && last_beat) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!out_vld_q || out_ready) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_q <= 1'b1;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign dma_read_ctrl_valid       = req_vld_q;
    assign dma_read_ctrl_data_index  = req_q.index;
    assign dma_read_ctrl_data_length = req_q.length;
    assign dma_read_ctrl_data_size   = req_q.size;
    assign dma_read_chnl_ready       = chnl_rdy;
    assign out_valid                 = out_vld_q;
    assign out_north_bundle          = pair_q.north;
    assign out_west_bundle           = pair_q.west;
    assign busy                      = (state != ST_IDLE);
    assign load_done                 = done_q;

endmodule

// File: tb/tb_birukee_input_loader.sv
// Self-checking bench for birukee_input_loader: table of randomized transfers plus directed corner sequences.
module tb_birukee_input_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] base_index;
    logic [31:0] num_pairs;
    logic        dma_read_ctrl_valid;
    logic        dma_read_ctrl_ready;
    logic [31:0] dma_read_ctrl_data_index;
    logic [31:0] dma_read_ctrl_data_length;
    logic [2:0]  dma_read_ctrl_data_size;
    logic        dma_read_chnl_valid;
    logic        dma_read_chnl_ready;
    logic [63:0] dma_read_chnl_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_north_bundle;
    logic [63:0] out_west_bundle;
    logic        busy;
    logic        load_done;

    int total = 0;
    int bad   = 0;

    birukee_input_loader dut (
        .clk                       (clk),
        .rst                       (rst),
        .start                     (start),
        .base_index                (base_index),
        .num_pairs                 (num_pairs),
        .dma_read_ctrl_valid       (dma_read_ctrl_valid),
        .dma_read_ctrl_ready       (dma_read_ctrl_ready),
        .dma_read_ctrl_data_index  (dma_read_ctrl_data_index),
        .dma_read_ctrl_data_length (dma_read_ctrl_data_length),
        .dma_read_ctrl_data_size   (dma_read_ctrl_data_size),
        .dma_read_chnl_valid       (dma_read_chnl_valid),
        .dma_read_chnl_ready       (dma_read_chnl_ready),
        .dma_read_chnl_data        (dma_read_chnl_data),
        .out_valid                 (out_valid),
        .out_ready                 (out_ready),
        .out_north_bundle          (out_north_bundle),
        .out_west_bundle           (out_west_bundle),
        .busy                      (busy),
        .load_done                 (load_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] base;
        int          np;
        logic [31:0] exp_len;
        int          ctrl_delay;
        int          vpct;
        int          rpct;
        int          stall;
        int          spulse;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_ctrl"}, {dma_read_ctrl_valid, dma_read_ctrl_data_index, dma_read_ctrl_data_length,
                             dma_read_ctrl_data_size, dma_read_chnl_ready, out_valid, busy, load_done}, 0);
        chk({tag, "_north"}, out_north_bundle, 0);
        chk({tag, "_west"}, out_west_bundle, 0);
    endtask

    task automatic idle_inputs();
        start               = 1'b0;
        dma_read_ctrl_ready = 1'b0;
        dma_read_chnl_valid = 1'b0;
        dma_read_chnl_data  = 64'h0;
        out_ready           = 1'b0;
    endtask

    // One full transfer against a scoreboard: pair k must equal {beat 2k, beat 2k+1}.
    task automatic run_xfer(input vec_t v);
        logic [63:0] beats[$];
        logic [63:0] prev_n;
        logic [63:0] prev_w;
        logic        prev_stall;
        int          sent, got, req_cnt, done_cnt, req_cycles, extra;
        bit          finished;
        beats = {};
        for (int i = 0; i < 2 * v.np; i++) beats.push_back({$urandom, $urandom});
        sent = 0; got = 0; req_cnt = 0; done_cnt = 0; req_cycles = 0; extra = 0;
        prev_stall = 1'b0; prev_n = '0; prev_w = '0; finished = 1'b0;

        start = 1'b1; base_index = v.base; num_pairs = v.np;
        @(posedge clk); #1;
        start = 1'b0; base_index = 32'hDEAD_BEEF; num_pairs = 32'd7;

        for (int c = 0; c < 3000 && !finished; c++) begin
            dma_read_ctrl_ready = (req_cycles >= v.ctrl_delay);
            dma_read_chnl_valid = (req_cnt > 0) && (sent < 2 * v.np) && ($urandom_range(99) < v.vpct);
            dma_read_chnl_data  = (sent < 2 * v.np) ? beats[sent] : 64'h0;
            out_ready           = (c >= v.stall) && ($urandom_range(99) < v.rpct);
            start               = (c == v.spulse);
            #1;
            if (prev_stall) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_north", out_north_bundle, prev_n);
                chk("hold_west", out_west_bundle, prev_w);
            end
            if (dma_read_ctrl_valid) begin
                chk("req_index", dma_read_ctrl_data_index, v.base);
                chk("req_length", dma_read_ctrl_data_length, v.exp_len);
                chk("req_size", dma_read_ctrl_data_size, 3'b011);
                req_cycles++;
                if (dma_read_ctrl_ready) req_cnt++;
            end
            if (v.stall > 0 && c == v.stall - 1) begin
                chk("stall_beats_taken", sent, 3);
                chk("stall_odd_ready", dma_read_chnl_ready, 0);
            end
            if (out_valid && out_ready) begin
                if (got < v.np) begin
                    chk("pair_north", out_north_bundle, beats[2 * got]);
                    chk("pair_west", out_west_bundle, beats[2 * got + 1]);
                end
                got++;
            end
            if (dma_read_chnl_valid && dma_read_chnl_ready) sent++;
            if (load_done) begin
                chk("done_busy_low", busy, 0);
                done_cnt++;
                finished = 1'b1;
            end
            prev_stall = out_valid && !out_ready;
            prev_n     = out_north_bundle;
            prev_w     = out_west_bundle;
            if (!finished) begin
                @(posedge clk); #1;
            end
        end
        chk("xfer_finished", finished, 1);
        chk("xfer_pairs", got, v.np);
        chk("xfer_beats", sent, 2 * v.np);
        chk("xfer_requests", req_cnt, 1);
        chk("xfer_ctrl_waits", req_cycles, v.ctrl_delay + 1);

        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            extra += int'(load_done) + int'(dma_read_ctrl_valid) + int'(out_valid) + int'(busy);
        end
        chk("post_idle", extra, 0);
    endtask

    task automatic seq_two_beats();
        logic [63:0] b0;
        logic [63:0] b1;
        bit          seen;
        b0 = 64'h1111_1111_1111_1111;
        b1 = 64'h2222_2222_2222_2222;
        seen = 1'b0;
        start = 1'b1; base_index = 32'h0; num_pairs = 32'd1;
        @(posedge clk); #1;
        start = 1'b0;
        dma_read_ctrl_ready = 1'b1;
        #1;
        chk("tb_req_valid", dma_read_ctrl_valid, 1);
        chk("tb_req_len", dma_read_ctrl_data_length, 2);
        chk("tb_chnl_rdy_in_req", dma_read_chnl_ready, 0);
        @(posedge clk); #1;
        dma_read_ctrl_ready = 1'b0;
        dma_read_chnl_valid = 1'b1; dma_read_chnl_data = b0; out_ready = 1'b1;
        #1;
        chk("tb_rdy_even", dma_read_chnl_ready, 1);
        @(posedge clk); #1;
        dma_read_chnl_data = b1;
        #1;
        chk("tb_rdy_odd", dma_read_chnl_ready, 1);
        chk("tb_valid_before", out_valid, 0);
        @(posedge clk); #1;
        dma_read_chnl_valid = 1'b0;
        #1;
        chk("tb_valid_after", out_valid, 1);
        chk("tb_north", out_north_bundle, b0);
        chk("tb_west", out_west_bundle, b1);
        for (int c = 0; c < 10 && !seen; c++) begin
            @(posedge clk); #1;
            seen = load_done;
        end
        chk("tb_done", seen, 1);
        idle_inputs();
        @(posedge clk); #1;
        chk("tb_done_one_cycle", load_done, 0);
    endtask

    task automatic seq_zero_pairs();
        start = 1'b1; base_index = 32'h77; num_pairs = 32'd0;
        @(posedge clk); #1;
        start = 1'b0;
        chk("zp_no_req_1", dma_read_ctrl_valid, 0);
        chk("zp_done_early", load_done, 0);
        chk("zp_busy", busy, 1);
        @(posedge clk); #1;
        chk("zp_no_req_2", dma_read_ctrl_valid, 0);
        chk("zp_done", load_done, 1);
        chk("zp_idle", busy, 0);
        @(posedge clk); #1;
        chk("zp_done_cleared", load_done, 0);
    endtask

    task automatic seq_reset_mid();
        int   sent;
        vec_t v;
        sent = 0;
        start = 1'b1; base_index = 32'h300; num_pairs = 32'd4;
        @(posedge clk); #1;
        start = 1'b0;
        dma_read_ctrl_ready = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 50 && sent < 3; c++) begin
            dma_read_chnl_valid = 1'b1;
            dma_read_chnl_data  = {$urandom, $urandom};
            #1;
            if (dma_read_chnl_valid && dma_read_chnl_ready) sent++;
            @(posedge clk); #1;
        end
        chk("rm_beats_before_rst", sent, 3);
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset("rm_reset");
        rst = 1'b0;
        idle_inputs();
        @(posedge clk); #1;
        v = '{base: 32'h400, np: 1, exp_len: 32'd2, ctrl_delay: 1, vpct: 100, rpct: 100, stall: 0, spulse: -1};
        run_xfer(v);
    endtask

    initial begin
        vecs[0] = '{base: 32'h0000_0100, np: 3,  exp_len: 32'd6,  ctrl_delay: 4, vpct: 100, rpct: 100, stall: 0,  spulse: -1};
        vecs[1] = '{base: 32'h0000_2000, np: 2,  exp_len: 32'd4,  ctrl_delay: 0, vpct: 100, rpct: 100, stall: 10, spulse: -1};
        vecs[2] = '{base: 32'hABCD_0000, np: 5,  exp_len: 32'd10, ctrl_delay: 1, vpct: 60,  rpct: 50,  stall: 0,  spulse: 8};
        vecs[3] = '{base: 32'hFFFF_FFF0, np: 8,  exp_len: 32'd16, ctrl_delay: 2, vpct: 40,  rpct: 70,  stall: 0,  spulse: -1};
        vecs[4] = '{base: 32'h0000_0000, np: 1,  exp_len: 32'd2,  ctrl_delay: 0, vpct: 100, rpct: 100, stall: 0,  spulse: -1};
        vecs[5] = '{base: 32'h0000_0055, np: 16, exp_len: 32'd32, ctrl_delay: 3, vpct: 80,  rpct: 30,  stall: 0,  spulse: 20};

        rst = 1'b1;
        base_index = 32'h0;
        num_pairs  = 32'h0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        check_reset("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        seq_two_beats();
        seq_zero_pairs();
        for (int i = 0; i < 6; i++) run_xfer(vecs[i]);
        seq_reset_mid();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
